// File: rtl/pipe_fwd_pkg.sv
// pipe_fwd_pkg
// Shared encodings for the ID-stage operand forwarding / hazard unit.
//   KIND_*  : result kind carried by the EXE and MEM stages with their write enable
//   CAUSE_* : stall_cause encoding, numerically ordered so that a lower non-zero
//             code has higher priority
package pipe_fwd_pkg;

  localparam logic [1:0] KIND_ALU  = 2'b00;
  localparam logic [1:0] KIND_LOAD = 2'b01;
  localparam logic [1:0] KIND_LINK = 2'b10;
  localparam logic [1:0] KIND_MDU  = 2'b11;

  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_LOAD   = 2'b01;
  localparam logic [1:0] CAUSE_MDU    = 2'b10;
  localparam logic [1:0] CAUSE_STRUCT = 2'b11;

endpackage

// File: rtl/mdu_pend_tracker.sv
// mdu_pend_tracker
// One-entry pending-write scoreboard for the multi-cycle MDU.
// An issue loads the entry with the destination and a countdown of MDU_LAT-1;
// the countdown runs every cycle regardless of pipeline stalls. When it reaches
// zero the entry requests the register-file write port for exactly that cycle
// and is released on the following edge (unless a new issue reloads it).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   issue        load the entry this edge
//   issue_addr   destination register of the issuing op
//   pend_valid   entry occupied (also the tracker's visible state)
//   pend_addr    destination held by the entry
//   wb_fire      entry is writing back this cycle
//   cnt_gt1      more than one cycle left before writeback
module mdu_pend_tracker #(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [REG_AW-1:0] issue_addr,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_addr,
  output logic              wb_fire,
  output logic              cnt_gt1
);

  localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      cnt        <= '0;
    end else if (issue) begin
      pend_valid <= 1'b1;
      pend_addr  <= issue_addr;
      cnt        <= CNT_INIT;
    end else if (pend_valid) begin
      if (cnt != '0) cnt <= cnt - CNT_ONE;
      else           pend_valid <= 1'b0;
    end
  end

  assign wb_fire = pend_valid && (cnt == '0);
  assign cnt_gt1 = pend_valid && (cnt > CNT_ONE);

endmodule

// File: rtl/operand_fwd_scoreboard.sv
// operand_fwd_scoreboard
// ID-stage operand forwarding and hazard unit. Each read port takes the newest
// in-flight value for its register from EXE, MEM, WB or a completing MDU
// writeback; results that are not yet available (EXE load, any in-flight MDU
// result) raise a stall. A one-entry tracker sequences MDU writebacks, and a
// saturating counter records stalled cycles.
// Ports:
//   id_*          ID instruction: read addresses/enables, RF data, destination, MDU flag
//   exe_*, mem_*  in-flight destinations, result kinds and candidate values
//   wb_*          WB-stage register write
//   mdu_result    MDU result, consumed while mdu_wb_req=1
//   flush         squashes an MDU issue from EXE this cycle
//   op_out        forwarded operands, port p at [p*DATA_W +: DATA_W]
//   stall         hold IF/ID and insert a bubble into EXE
//   stall_cause   00 none, 01 load-use, 10 MDU RAW/WAW, 11 MDU structural
//   mdu_wb_req    drive the RF second write port (mdu_wb_addr <= mdu_result)
//   mdu_busy      an MDU write is pending
//   stall_cnt     saturating count of stalled cycles
// Handshake: mdu_wb_req is a one-cycle, valid-only request with no ready; the
// register file's second write port must accept it in the cycle it is raised.
module operand_fwd_scoreboard
  import pipe_fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_RP  = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RP*REG_AW-1:0] id_raddr,
  input  logic [NUM_RP-1:0]        id_ren,
  input  logic [NUM_RP*DATA_W-1:0] id_rdata,
  input  logic                     id_we,
  input  logic [REG_AW-1:0]        id_waddr,
  input  logic                     id_is_mdu,
  input  logic                     exe_we,
  input  logic [REG_AW-1:0]        exe_waddr,
  input  logic [1:0]               exe_kind,
  input  logic [DATA_W-1:0]        exe_Z,
  input  logic [DATA_W-1:0]        exe_NPC,
  input  logic                     mem_we,
  input  logic [REG_AW-1:0]        mem_waddr,
  input  logic [1:0]               mem_kind,
  input  logic [DATA_W-1:0]        mem_Z,
  input  logic [DATA_W-1:0]        mem_NPC,
  input  logic [DATA_W-1:0]        mem_ldata,
  input  logic                     wb_we,
  input  logic [REG_AW-1:0]        wb_waddr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic [DATA_W-1:0]        mdu_result,
  input  logic                     flush,
  output logic [NUM_RP*DATA_W-1:0] op_out,
  output logic                     stall,
  output logic [1:0]               stall_cause,
  output logic                     mdu_wb_req,
  output logic [REG_AW-1:0]        mdu_wb_addr,
  output logic                     mdu_busy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam bit LAT_GT1 = (MDU_LAT > 1);

  logic              pend_valid;
  logic [REG_AW-1:0] pend_addr;
  logic              wb_fire;
  logic              cnt_gt1;
  logic              issue_cand;
  logic              mdu_issue;
  logic [NUM_RP-1:0] load_haz;
  logic [NUM_RP-1:0] mdu_haz;
  logic              waw_haz;
  logic              struct_haz;

  // An MDU op in EXE that would issue if the pipeline were not stalled.
  assign issue_cand = exe_we && (exe_kind == KIND_MDU) && !flush;
  assign mdu_issue  = issue_cand && !stall;

  mdu_pend_tracker #(
    .REG_AW (REG_AW),
    .MDU_LAT(MDU_LAT)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (mdu_issue),
    .issue_addr(exe_waddr),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .wb_fire   (wb_fire),
    .cnt_gt1   (cnt_gt1)
  );

  assign mdu_wb_req  = wb_fire;
  assign mdu_wb_addr = wb_fire ? pend_addr : '0;
  assign mdu_busy    = pend_valid;

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    logic [REG_AW-1:0] r;
    logic [DATA_W-1:0] op;
    logic              hz_load;
    logic              hz_mdu;

    assign r = id_raddr[p*REG_AW +: REG_AW];

    // Youngest producer wins: EXE, then MEM, then WB, then the MDU writeback.
    always_comb begin
      op      = id_rdata[p*DATA_W +: DATA_W];
      hz_load = 1'b0;
      hz_mdu  = 1'b0;
      if (r == '0) begin
        op = '0;
      end else if (exe_we && (exe_waddr == r)) begin
        case (exe_kind)
          KIND_ALU:  op = exe_Z;
          KIND_LINK: op = exe_NPC;
          KIND_LOAD: hz_load = 1'b1;
          default:   hz_mdu  = 1'b1;
        endcase
      end else if (mem_we && (mem_waddr == r)) begin
        case (mem_kind)
          KIND_ALU:  op = mem_Z;
          KIND_LINK: op = mem_NPC;
          KIND_LOAD: op = mem_ldata;
          default:   hz_mdu = 1'b1;
        endcase
      end else if (wb_we && (wb_waddr == r)) begin
        op = wb_data;
      end else if (wb_fire && (pend_addr == r)) begin
        op = mdu_result;
      end else if (pend_valid && (pend_addr == r)) begin
        hz_mdu = 1'b1;
      end
    end

    assign op_out[p*DATA_W +: DATA_W] = op;
    assign load_haz[p] = hz_load && id_ren[p];
    assign mdu_haz[p]  = hz_mdu && id_ren[p];
  end

  // A write landing on the pending register before the MDU writes it back
  // would be overwritten by the late MDU result.
  assign waw_haz = id_we && (id_waddr != '0) && pend_valid && !wb_fire &&
                   (id_waddr == pend_addr);

  // The issue term uses the candidate rather than mdu_issue: mdu_issue depends
  // on stall, so using it here would form a combinational loop. When an EXE
  // MDU op meets an ID MDU op, the stall wins and the EXE op does not issue.
  assign struct_haz = id_is_mdu && (cnt_gt1 || (issue_cand && LAT_GT1));

  always_comb begin
    stall_cause = CAUSE_NONE;
    if (|load_haz)                 stall_cause = CAUSE_LOAD;
    else if ((|mdu_haz) || waw_haz) stall_cause = CAUSE_MDU;
    else if (struct_haz)           stall_cause = CAUSE_STRUCT;
  end

  assign stall = |stall_cause;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_operand_fwd_scoreboard.sv
// tb_operand_fwd_scoreboard
// Table of single-cycle forwarding vectors plus hand-written multi-cycle
// sequences for MDU writeback, structural/WAW stalls, reset and counter saturation.
module tb_operand_fwd_scoreboard;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int NUM_RP  = 2;
  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 4;
  localparam int W       = 32;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_RP*REG_AW-1:0] id_raddr;
  logic [NUM_RP-1:0]        id_ren;
  logic [NUM_RP*DATA_W-1:0] id_rdata;
  logic                     id_we;
  logic [REG_AW-1:0]        id_waddr;
  logic                     id_is_mdu;
  logic                     exe_we;
  logic [REG_AW-1:0]        exe_waddr;
  logic [1:0]               exe_kind;
  logic [DATA_W-1:0]        exe_Z;
  logic [DATA_W-1:0]        exe_NPC;
  logic                     mem_we;
  logic [REG_AW-1:0]        mem_waddr;
  logic [1:0]               mem_kind;
  logic [DATA_W-1:0]        mem_Z;
  logic [DATA_W-1:0]        mem_NPC;
  logic [DATA_W-1:0]        mem_ldata;
  logic                     wb_we;
  logic [REG_AW-1:0]        wb_waddr;
  logic [DATA_W-1:0]        wb_data;
  logic [DATA_W-1:0]        mdu_result;
  logic                     flush;
  logic [NUM_RP*DATA_W-1:0] op_out;
  logic                     stall;
  logic [1:0]               stall_cause;
  logic                     mdu_wb_req;
  logic [REG_AW-1:0]        mdu_wb_addr;
  logic                     mdu_busy;
  logic [CNT_W-1:0]         stall_cnt;

  operand_fwd_scoreboard #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .NUM_RP (NUM_RP),
    .MDU_LAT(MDU_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_raddr   (id_raddr),
    .id_ren     (id_ren),
    .id_rdata   (id_rdata),
    .id_we      (id_we),
    .id_waddr   (id_waddr),
    .id_is_mdu  (id_is_mdu),
    .exe_we     (exe_we),
    .exe_waddr  (exe_waddr),
    .exe_kind   (exe_kind),
    .exe_Z      (exe_Z),
    .exe_NPC    (exe_NPC),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_kind   (mem_kind),
    .mem_Z      (mem_Z),
    .mem_NPC    (mem_NPC),
    .mem_ldata  (mem_ldata),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_data    (wb_data),
    .mdu_result (mdu_result),
    .flush      (flush),
    .op_out     (op_out),
    .stall      (stall),
    .stall_cause(stall_cause),
    .mdu_wb_req (mdu_wb_req),
    .mdu_wb_addr(mdu_wb_addr),
    .mdu_busy   (mdu_busy),
    .stall_cnt  (stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_next(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: expected queue empty, got 0x%0h", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic quiet();
    id_raddr   = '0;
    id_ren     = '0;
    id_rdata   = {32'h0000_2000, 32'h0000_1000};
    id_we      = 1'b0;
    id_waddr   = '0;
    id_is_mdu  = 1'b0;
    exe_we     = 1'b0;
    exe_waddr  = '0;
    exe_kind   = 2'b00;
    exe_Z      = 32'h11;
    exe_NPC    = 32'h22;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_kind   = 2'b00;
    mem_Z      = 32'h33;
    mem_NPC    = 32'h44;
    mem_ldata  = 32'hCAFE;
    wb_we      = 1'b0;
    wb_waddr   = '0;
    wb_data    = 32'h55;
    mdu_result = 32'hBEEF_0009;
    flush      = 1'b0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    quiet();
    cyc();
    @(negedge clk);
    check("rst_busy", mdu_busy, 0);
    check("rst_wb_req", mdu_wb_req, 0);
    check("rst_wb_addr", mdu_wb_addr, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_stall", stall, 0);
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic issue_mdu(input logic [4:0] rd);
    exe_we    = 1'b1;
    exe_waddr = rd;
    exe_kind  = 2'b11;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  ren;
    logic        x_we;
    logic [4:0]  x_wa;
    logic [1:0]  x_k;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [1:0]  m_k;
    logic        w_we;
    logic [4:0]  w_wa;
    logic        care0;
    logic [31:0] e_op0;
    logic        care1;
    logic [31:0] e_op1;
    logic [1:0]  e_cause;
  } vec_t;

  function automatic vec_t mk(
    input logic [4:0] ra0, input logic [4:0] ra1, input logic [1:0] ren,
    input logic x_we, input logic [4:0] x_wa, input logic [1:0] x_k,
    input logic m_we, input logic [4:0] m_wa, input logic [1:0] m_k,
    input logic w_we, input logic [4:0] w_wa,
    input logic care0, input logic [31:0] e_op0,
    input logic care1, input logic [31:0] e_op1, input logic [1:0] e_cause);
    vec_t v;
    v.ra0 = ra0; v.ra1 = ra1; v.ren = ren;
    v.x_we = x_we; v.x_wa = x_wa; v.x_k = x_k;
    v.m_we = m_we; v.m_wa = m_wa; v.m_k = m_k;
    v.w_we = w_we; v.w_wa = w_wa;
    v.care0 = care0; v.e_op0 = e_op0;
    v.care1 = care1; v.e_op1 = e_op1; v.e_cause = e_cause;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t tv[NV];

  initial begin
    // Data constants: rdata p0=0x1000 p1=0x2000, exe_Z=0x11, exe_NPC=0x22,
    // mem_Z=0x33, mem_NPC=0x44, mem_ldata=0xCAFE, wb_data=0x55.
    //          ra0 ra1 ren    exe          mem          wb       op0          op1          cause
    tv[0]  = mk(3,  5,  2'b11, 1, 5,  2'b00, 0, 0, 2'b00, 0, 0, 1, 32'h1000, 1, 32'h11,   2'b00);
    tv[1]  = mk(5,  3,  2'b11, 1, 5,  2'b10, 0, 0, 2'b00, 0, 0, 1, 32'h22,   1, 32'h2000, 2'b00);
    tv[2]  = mk(8,  0,  2'b11, 1, 8,  2'b01, 0, 0, 2'b00, 0, 0, 0, 32'h0,    1, 32'h0,    2'b01);
    tv[3]  = mk(3,  8,  2'b01, 1, 8,  2'b01, 0, 0, 2'b00, 0, 0, 1, 32'h1000, 0, 32'h0,    2'b00);
    tv[4]  = mk(0,  0,  2'b11, 1, 0,  2'b01, 0, 0, 2'b00, 0, 0, 1, 32'h0,    1, 32'h0,    2'b00);
    tv[5]  = mk(8,  3,  2'b11, 0, 0,  2'b00, 1, 8, 2'b01, 0, 0, 1, 32'hCAFE, 1, 32'h2000, 2'b00);
    tv[6]  = mk(6,  3,  2'b11, 0, 0,  2'b00, 1, 6, 2'b00, 0, 0, 1, 32'h33,   1, 32'h2000, 2'b00);
    tv[7]  = mk(3,  7,  2'b11, 0, 0,  2'b00, 1, 7, 2'b10, 0, 0, 1, 32'h1000, 1, 32'h44,   2'b00);
    tv[8]  = mk(7,  3,  2'b01, 0, 0,  2'b00, 1, 7, 2'b11, 0, 0, 0, 32'h0,    1, 32'h2000, 2'b10);
    tv[9]  = mk(4,  4,  2'b11, 0, 0,  2'b00, 0, 0, 2'b00, 1, 4, 1, 32'h55,   1, 32'h55,   2'b00);
    tv[10] = mk(4,  3,  2'b11, 1, 4,  2'b00, 1, 4, 2'b00, 1, 4, 1, 32'h11,   1, 32'h2000, 2'b00);
    tv[11] = mk(3,  4,  2'b11, 0, 0,  2'b00, 1, 4, 2'b00, 1, 4, 1, 32'h1000, 1, 32'h33,   2'b00);
    tv[12] = mk(3,  10, 2'b10, 1, 10, 2'b11, 0, 0, 2'b00, 0, 0, 1, 32'h1000, 0, 32'h0,    2'b10);
    tv[13] = mk(8,  9,  2'b11, 1, 8,  2'b01, 1, 9, 2'b11, 0, 0, 0, 32'h0,    0, 32'h0,    2'b01);
    tv[14] = mk(1,  2,  2'b11, 1, 6,  2'b01, 1, 7, 2'b00, 1, 4, 1, 32'h1000, 1, 32'h2000, 2'b00);
  end

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    quiet();
    #1;
    do_reset();

    // Table vectors: flush held high so EXE MDU kinds never issue.
    for (int i = 0; i < NV; i++) begin
      quiet();
      flush     = 1'b1;
      id_raddr  = {tv[i].ra1, tv[i].ra0};
      id_ren    = tv[i].ren;
      exe_we    = tv[i].x_we;
      exe_waddr = tv[i].x_wa;
      exe_kind  = tv[i].x_k;
      mem_we    = tv[i].m_we;
      mem_waddr = tv[i].m_wa;
      mem_kind  = tv[i].m_k;
      wb_we     = tv[i].w_we;
      wb_waddr  = tv[i].w_wa;
      if (tv[i].care0) exp_q.push_back(tv[i].e_op0);
      if (tv[i].care1) exp_q.push_back(tv[i].e_op1);
      exp_q.push_back(W'(tv[i].e_cause));
      exp_q.push_back(W'(tv[i].e_cause != 2'b00));
      @(negedge clk);
      if (tv[i].care0) check_next($sformatf("v%0d_op0", i), op_out[31:0]);
      if (tv[i].care1) check_next($sformatf("v%0d_op1", i), op_out[63:32]);
      check_next($sformatf("v%0d_cause", i), W'(stall_cause));
      check_next($sformatf("v%0d_stall", i), W'(stall));
      cyc();
    end
    check("tbl_no_issue_busy", mdu_busy, 0);

    // Load-use then MEM-stage load forward.
    do_reset();
    exe_we = 1'b1; exe_waddr = 8; exe_kind = 2'b01;
    id_raddr = {5'd0, 5'd8}; id_ren = 2'b01;
    @(negedge clk);
    check("lu_cause", stall_cause, 2'b01);
    check("lu_stall", stall, 1);
    cyc();
    exe_we = 1'b0; exe_kind = 2'b00;
    mem_we = 1'b1; mem_waddr = 8; mem_kind = 2'b01;
    @(negedge clk);
    check("lu_mem_op", op_out[31:0], 32'hCAFE);
    check("lu_mem_stall", stall, 0);
    cyc();

    // MDU RAW: issue r9 at T, ID reads r9 from T+1.
    do_reset();
    issue_mdu(9);
    @(negedge clk);
    check("mdu_t_stall", stall, 0);
    check("mdu_t_busy", mdu_busy, 0);
    cyc();
    quiet();
    id_raddr = {5'd0, 5'd9}; id_ren = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("mdu_t%0d_cause", k), stall_cause, 2'b10);
      check($sformatf("mdu_t%0d_busy", k), mdu_busy, 1);
      check($sformatf("mdu_t%0d_wbreq", k), mdu_wb_req, 0);
      cyc();
    end
    @(negedge clk);
    check("mdu_t4_wbreq", mdu_wb_req, 1);
    check("mdu_t4_wbaddr", mdu_wb_addr, 9);
    check("mdu_t4_op", op_out[31:0], 32'hBEEF_0009);
    check("mdu_t4_stall", stall, 0);
    check("mdu_t4_cnt", stall_cnt, 3);
    cyc();
    @(negedge clk);
    check("mdu_t5_busy", mdu_busy, 0);
    check("mdu_t5_wbreq", mdu_wb_req, 0);
    check("mdu_t5_op", op_out[31:0], 32'h1000);
    cyc();

    // Structural and WAW against a pending MDU write to r9.
    do_reset();
    issue_mdu(9);
    cyc();
    quiet();
    id_is_mdu = 1'b1;
    @(negedge clk);
    check("st_t1_cause", stall_cause, 2'b11);
    cyc();
    id_is_mdu = 1'b0; id_we = 1'b1; id_waddr = 9;
    @(negedge clk);
    check("waw_t2_cause", stall_cause, 2'b10);
    cyc();
    id_we = 1'b0; id_is_mdu = 1'b1;
    @(negedge clk);
    check("st_t3_cause", stall_cause, 2'b00);
    cyc();
    id_is_mdu = 1'b0; id_we = 1'b1; id_waddr = 9;
    @(negedge clk);
    check("waw_t4_cause", stall_cause, 2'b00);
    check("waw_t4_wbreq", mdu_wb_req, 1);
    cyc();

    // Reset in the middle of a pending MDU op.
    do_reset();
    issue_mdu(9);
    cyc();
    quiet();
    id_raddr = {5'd0, 5'd9}; id_ren = 2'b01;
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_t2_cnt", stall_cnt, 1);
    cyc();
    rst_n = 1'b1;
    quiet();
    @(negedge clk);
    check("mr_t3_busy", mdu_busy, 0);
    check("mr_t3_cnt", stall_cnt, 0);
    check("mr_t3_wbreq", mdu_wb_req, 0);
    cyc();
    @(negedge clk);
    check("mr_t4_wbreq", mdu_wb_req, 0);
    check("mr_t4_busy", mdu_busy, 0);
    cyc();

    // Stall counter saturation with a 4-bit counter.
    do_reset();
    exe_we = 1'b1; exe_waddr = 8; exe_kind = 2'b01;
    id_raddr = {5'd0, 5'd8}; id_ren = 2'b01;
    repeat (14) cyc();
    @(negedge clk);
    check("sat_14", stall_cnt, 14);
    repeat (6) cyc();
    @(negedge clk);
    check("sat_20", stall_cnt, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
